// File: rtl/frame_pixel_server.sv
// frame_pixel_server: loads a current and a reference frame from a pixel
// stream into two single-read-port buffers, then serves 7+7 point hexagon
// fetches serially, one point per frame per cycle.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_LOAD  | accepting stream pixels, current frame then reference frame
// S_READY | both frames resident (go=1), waiting for a fetch request
// S_FETCH | issuing one read per frame per cycle, points 0..6
// S_DONE  | last read in flight; pixel_valid follows the final capture
module frame_pixel_server #(
    parameter int FRAME_DIM = 96,
    parameter int COORD_W   = 7,
    parameter int PIX_W     = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_valid,
    input  logic [PIX_W-1:0]   wr_pixel,
    output logic               wr_ready,
    input  logic               reload,
    output logic               go,
    input  logic               fetchpixeldata,
    input  logic [COORD_W-1:0] x_coordinates_currentframe0,
    input  logic [COORD_W-1:0] x_coordinates_currentframe1,
    input  logic [COORD_W-1:0] x_coordinates_currentframe2,
    input  logic [COORD_W-1:0] x_coordinates_currentframe3,
    input  logic [COORD_W-1:0] x_coordinates_currentframe4,
    input  logic [COORD_W-1:0] x_coordinates_currentframe5,
    input  logic [COORD_W-1:0] x_coordinates_currentframe6,
    input  logic [COORD_W-1:0] y_coordinates_currentframe0,
    input  logic [COORD_W-1:0] y_coordinates_currentframe1,
    input  logic [COORD_W-1:0] y_coordinates_currentframe2,
    input  logic [COORD_W-1:0] y_coordinates_currentframe3,
    input  logic [COORD_W-1:0] y_coordinates_currentframe4,
    input  logic [COORD_W-1:0] y_coordinates_currentframe5,
    input  logic [COORD_W-1:0] y_coordinates_currentframe6,
    input  logic [COORD_W-1:0] x_coordinates_referenceframe0,
    input  logic [COORD_W-1:0] x_coordinates_referenceframe1,
    input  logic [COORD_W-1:0] x_coordinates_referenceframe2,
    input  logic [COORD_W-1:0] x_coordinates_referenceframe3,
    input  logic [COORD_W-1:0] x_coordinates_referenceframe4,
    input  logic [COORD_W-1:0] x_coordinates_referenceframe5,
    input  logic [COORD_W-1:0] x_coordinates_referenceframe6,
    input  logic [COORD_W-1:0] y_coordinates_referenceframe0,
    input  logic [COORD_W-1:0] y_coordinates_referenceframe1,
    input  logic [COORD_W-1:0] y_coordinates_referenceframe2,
    input  logic [COORD_W-1:0] y_coordinates_referenceframe3,
    input  logic [COORD_W-1:0] y_coordinates_referenceframe4,
    input  logic [COORD_W-1:0] y_coordinates_referenceframe5,
    input  logic [COORD_W-1:0] y_coordinates_referenceframe6,
    output logic [PIX_W-1:0]   coordinate_values_currentframe0,
    output logic [PIX_W-1:0]   coordinate_values_currentframe1,
    output logic [PIX_W-1:0]   coordinate_values_currentframe2,
    output logic [PIX_W-1:0]   coordinate_values_currentframe3,
    output logic [PIX_W-1:0]   coordinate_values_currentframe4,
    output logic [PIX_W-1:0]   coordinate_values_currentframe5,
    output logic [PIX_W-1:0]   coordinate_values_currentframe6,
    output logic [PIX_W-1:0]   coordinate_values_referenceframe0,
    output logic [PIX_W-1:0]   coordinate_values_referenceframe1,
    output logic [PIX_W-1:0]   coordinate_values_referenceframe2,
    output logic [PIX_W-1:0]   coordinate_values_referenceframe3,
    output logic [PIX_W-1:0]   coordinate_values_referenceframe4,
    output logic [PIX_W-1:0]   coordinate_values_referenceframe5,
    output logic [PIX_W-1:0]   coordinate_values_referenceframe6,
    output logic               busy,
    output logic               pixel_valid
);
    localparam int NPIX  = FRAME_DIM * FRAME_DIM;
    localparam int AW    = 14;
    localparam int CNT_W = 15;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(2 * NPIX - 1);

    typedef enum logic [1:0] {S_LOAD, S_READY, S_FETCH, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [2:0]         idx_q;
    logic [COORD_W-1:0] cx_in [7], cy_in [7], rx_in [7], ry_in [7];
    logic [COORD_W-1:0] cx_q  [7], cy_q  [7], rx_q  [7], ry_q  [7];
    logic [PIX_W-1:0]   cur_mem [NPIX];
    logic [PIX_W-1:0]   ref_mem [NPIX];
    logic [PIX_W-1:0]   cur_rd, ref_rd;
    logic               rd_vld_q, cur_oob_q, ref_oob_q;
    logic [2:0]         rd_idx_q;
    logic [PIX_W-1:0]   cur_slot [7], ref_slot [7];
    logic               pv_q;
    logic               accept, last_pix, start, fetching;
    logic [COORD_W-1:0] cx_sel, cy_sel, rx_sel, ry_sel;
    logic [AW-1:0]      cur_addr, ref_addr;
    logic               cur_oob, ref_oob;

    assign cx_in = '{x_coordinates_currentframe0, x_coordinates_currentframe1,
                     x_coordinates_currentframe2, x_coordinates_currentframe3,
                     x_coordinates_currentframe4, x_coordinates_currentframe5,
                     x_coordinates_currentframe6};
    assign cy_in = '{y_coordinates_currentframe0, y_coordinates_currentframe1,
                     y_coordinates_currentframe2, y_coordinates_currentframe3,
                     y_coordinates_currentframe4, y_coordinates_currentframe5,
                     y_coordinates_currentframe6};
    assign rx_in = '{x_coordinates_referenceframe0, x_coordinates_referenceframe1,
                     x_coordinates_referenceframe2, x_coordinates_referenceframe3,
                     x_coordinates_referenceframe4, x_coordinates_referenceframe5,
                     x_coordinates_referenceframe6};
    assign ry_in = '{y_coordinates_referenceframe0, y_coordinates_referenceframe1,
                     y_coordinates_referenceframe2, y_coordinates_referenceframe3,
                     y_coordinates_referenceframe4, y_coordinates_referenceframe5,
                     y_coordinates_referenceframe6};

    // reload outranks both stream acceptance and fetch start
    assign accept   = wr_valid && (state_q == S_LOAD) && !reload;
    assign last_pix = accept && (cnt_q == LAST_CNT);
    assign start    = (state_q == S_READY) && fetchpixeldata && !reload;
    assign fetching = (state_q == S_FETCH);

    assign wr_ready    = (state_q == S_LOAD);
    assign go          = (state_q != S_LOAD);
    assign busy        = (state_q == S_FETCH) || (state_q == S_DONE);
    assign pixel_valid = pv_q;

    // Address and boundary check for the point currently being fetched
    always_comb begin
        cx_sel   = cx_q[idx_q];
        cy_sel   = cy_q[idx_q];
        rx_sel   = rx_q[idx_q];
        ry_sel   = ry_q[idx_q];
        cur_addr = AW'(cx_sel) * AW'(FRAME_DIM) + AW'(cy_sel);
        ref_addr = AW'(rx_sel) * AW'(FRAME_DIM) + AW'(ry_sel);
        cur_oob  = (cx_sel >= COORD_W'(FRAME_DIM)) || (cy_sel >= COORD_W'(FRAME_DIM));
        ref_oob  = (rx_sel >= COORD_W'(FRAME_DIM)) || (ry_sel >= COORD_W'(FRAME_DIM));
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_LOAD;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_LOAD:  if (last_pix) state_d = S_READY;
            S_READY: if (start) state_d = S_FETCH;
            S_FETCH: if (idx_q == 3'd6) state_d = S_DONE;
            S_DONE:  state_d = S_READY;
            default: state_d = S_LOAD;
        endcase
        if (reload) state_d = S_LOAD;
    end

    // Load counter: advances only on accepted pixels
    always_ff @(posedge clk) begin
        if (rst || reload)  cnt_q <= '0;
        else if (last_pix)  cnt_q <= '0;
        else if (accept)    cnt_q <= cnt_q + 1'b1;
    end

    // Point index and coordinate latch for the fetch in progress
    always_ff @(posedge clk) begin
        if (rst)           idx_q <= '0;
        else if (start)    idx_q <= '0;
        else if (fetching) idx_q <= idx_q + 1'b1;
        if (start) begin
            cx_q <= cx_in;
            cy_q <= cy_in;
            rx_q <= rx_in;
            ry_q <= ry_in;
        end
    end

    // Current-frame buffer: stream write port and fetch read port
    always_ff @(posedge clk) begin
        if (accept && cnt_q < CNT_W'(NPIX)) cur_mem[cnt_q[AW-1:0]] <= wr_pixel;
        if (fetching && !cur_oob) cur_rd <= cur_mem[cur_addr];
    end

    // Reference-frame buffer; the 14-bit wrap of the subtraction yields counter-NPIX
    always_ff @(posedge clk) begin
        if (accept && cnt_q >= CNT_W'(NPIX)) ref_mem[cnt_q[AW-1:0] - AW'(NPIX)] <= wr_pixel;
        if (fetching && !ref_oob) ref_rd <= ref_mem[ref_addr];
    end

    // Track which slot the in-flight read data belongs to
    always_ff @(posedge clk) begin
        if (rst || reload) rd_vld_q <= 1'b0;
        else               rd_vld_q <= fetching;
        rd_idx_q  <= idx_q;
        cur_oob_q <= cur_oob;
        ref_oob_q <= ref_oob;
    end

    // Capture returned pixels into their slots; out-of-frame points read as 0
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 7; i++) begin
                cur_slot[i] <= '0;
                ref_slot[i] <= '0;
            end
        end else if (rd_vld_q && !reload) begin
            cur_slot[rd_idx_q] <= cur_oob_q ? '0 : cur_rd;
            ref_slot[rd_idx_q] <= ref_oob_q ? '0 : ref_rd;
        end
    end

    // pixel_valid pulses in the cycle after the final capture
    always_ff @(posedge clk) begin
        if (rst) pv_q <= 1'b0;
        else     pv_q <= (state_q == S_DONE) && !reload;
    end

    assign coordinate_values_currentframe0   = cur_slot[0];
    assign coordinate_values_currentframe1   = cur_slot[1];
    assign coordinate_values_currentframe2   = cur_slot[2];
    assign coordinate_values_currentframe3   = cur_slot[3];
    assign coordinate_values_currentframe4   = cur_slot[4];
    assign coordinate_values_currentframe5   = cur_slot[5];
    assign coordinate_values_currentframe6   = cur_slot[6];
    assign coordinate_values_referenceframe0 = ref_slot[0];
    assign coordinate_values_referenceframe1 = ref_slot[1];
    assign coordinate_values_referenceframe2 = ref_slot[2];
    assign coordinate_values_referenceframe3 = ref_slot[3];
    assign coordinate_values_referenceframe4 = ref_slot[4];
    assign coordinate_values_referenceframe5 = ref_slot[5];
    assign coordinate_values_referenceframe6 = ref_slot[6];

endmodule

// File: doc/frame_pixel_server.md
Name: frame_pixel_server

Overview:
Memory-side responder for the hexagonal-search SAD engine. It receives the current and reference frames from a pixel stream and stores each in its own 96x96x8 on-chip frame buffer. It raises `go` once both frames are loaded. It then serves hexagon fetch requests: it latches 7 current-frame and 7 reference-frame coordinates and returns the 14 pixel values. Each frame buffer has one synchronous read port, so the 7 pixels per frame are read serially.

Parameters:
FRAME_DIM, 96, frame width and height in pixels (6x6 blocks of 16x16).
COORD_W, 7, coordinate width.
PIX_W, 8, pixel width.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  synchronous reset, active-high.
wr_valid  in  1  load-stream pixel valid.
wr_pixel  in  PIX_W  load-stream pixel.
wr_ready  out  1  high in LOAD state only; a pixel is accepted when wr_valid && wr_ready.
reload  in  1  one-cycle pulse: discard frames, return to LOAD.
go  out  1  both frames loaded; level signal.
fetchpixeldata  in  1  fetch request, sampled at a clock edge.
x_coordinates_currentframe0..6  in  COORD_W each  row coordinate of current-frame hexagon point n.
y_coordinates_currentframe0..6  in  COORD_W each  column coordinate of current-frame hexagon point n.
x_coordinates_referenceframe0..6  in  COORD_W each  row coordinate of reference-frame hexagon point n.
y_coordinates_referenceframe0..6  in  COORD_W each  column coordinate of reference-frame hexagon point n.
coordinate_values_currentframe0..6  out  PIX_W each  returned current-frame pixel n.
coordinate_values_referenceframe0..6  out  PIX_W each  returned reference-frame pixel n.
busy  out  1  fetch in progress.
pixel_valid  out  1  one-cycle pulse: all 14 pixel outputs updated.

Behaviour:
- Reset: state LOAD, load counter 0, go=0, busy=0, pixel_valid=0, all 14 pixel outputs 0, wr_ready=1 on the cycle after reset. Buffer contents are not cleared.
- States: LOAD, READY, FETCH, DONE.
- LOAD:
  - Stream order is the current frame in raster order (row x outer, column y inner), then the reference frame in the same order: 2*9216 = 18432 pixels.
  - The write address is the 15-bit load counter. Counter values 0..9215 write the current buffer at (x*96+y); values 9216..18431 write the reference buffer at counter-9216.
  - Gaps in wr_valid are allowed; the counter advances only on accepted pixels.
  - On acceptance of pixel 18431: next state READY, go=1 from that edge, wr_ready=0.
  - fetchpixeldata is ignored in LOAD.
- READY: go=1, busy=0. If fetchpixeldata=1 at edge E0:
  - latch all 28 coordinates;
  - busy=1 from E0;
  - index n=0;
  - go to FETCH.
- FETCH: each cycle, issue a read of current[n] and reference[n] at address x*96+y.
  - A point with x>=96 or y>=96 does not access the buffer. Its result is forced to 0 (boundary rule).
  - Read data returns one cycle later and is registered into output slot n.
  - Read n is issued in cycles E0..E6. Capture of slot n occurs at edge E(n+2).
  - After read 6 is issued, go to DONE.
- DONE: the final capture occurs at E8.
  - pixel_valid=1 for exactly the cycle following E8.
  - busy=0 after E8.
  - Next state READY.
- Latency: request edge to pixel_valid = 8 cycles. Back-to-back requests are accepted no sooner than E8.
- Pixel outputs:
  - Slots update progressively during FETCH; they are guaranteed stable only from pixel_valid.
  - They hold until the next accepted fetch overwrites them.
- fetchpixeldata while busy=1 is ignored, not queued.
- reload has priority over everything:
  - From READY/FETCH/DONE: next state LOAD, go=0, busy=0, counter=0.
  - A fetch in flight is aborted; no pixel_valid.
  - reload in LOAD restarts the counter at 0.
- reload and fetchpixeldata in the same cycle: reload wins and the fetch is dropped.
- rst mid-load or mid-fetch: return to reset values on the next edge.
- Address arithmetic: x*96+y computed as (x<<6)+(x<<5)+y in 14 bits; no wrap, max in-range address 9215.

Test Plan:
- Reset then load 18432 pixels: current = (x*96+y) mod 256, reference = (x*96+y+1) mod 256, one per cycle -> go rises on the edge accepting pixel 18431; wr_ready=0 afterward; go=0 throughout the load.
- Load with wr_valid toggling every other cycle -> go asserts after exactly 18432 accepted pixels; the counter holds during gaps.
- Fetch with all 14 points at (8,8), (8,10), (6,9), (6,7), (8,6), (10,7), (10,9) -> 8 cycles later pixel_valid pulse:
  - current = 8,10,73,71,6,199,201;
  - reference = 9,11,74,72,7,200,202.
- Reference point 3 at (100,5) and current point 5 at (40,96) -> those slots return 0, the others return correct values; latency is unchanged.
- Second fetchpixeldata asserted 3 cycles into a fetch -> ignored; exactly one pixel_valid; outputs match the first request.
- reload asserted at cycle E4 of a fetch -> no pixel_valid, go=0 next cycle, wr_ready=1; after reloading, go returns.
